// File: rtl/ps2_key_encoder.sv
`default_nettype none
// ============================================================================
//  Module  : ps2_key_encoder
//  Brief   : PS/2 keyboard line conditioner, frame deserialiser and
//            scan-code-set-2 prefix folder producing the 11-bit ps2_key word
//            {toggle, pressed, extended, code[7:0]}.
//  Revision: 1.0 - initial release
// ============================================================================
module ps2_key_encoder #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        key_strobe,
  output logic        frame_err
);

  localparam int FCW = (FILTER  > 1) ? $clog2(FILTER + 1)  : 1;
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Conditioned line state
  logic [1:0]     clk_sync;
  logic [1:0]     data_sync;
  logic           clk_filt;
  logic           data_filt;
  logic           clk_filt_d;
  logic [FCW-1:0] clk_cnt;
  logic [FCW-1:0] data_cnt;
  logic           fe;

  // Frame deserialiser state
  state_t         state;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           par_ok;
  logic [WDW-1:0] wd;
  logic           byte_valid;
  logic [7:0]     byte_data;

  // Prefix decoder state
  logic           ext;
  logic           brk;
  logic [2:0]     skip;

  // Two-flop synchronisers; idle bus level is high so they reset to 1
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Glitch filters: adopt a new level only after FILTER consecutive differing samples
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_filt   <= 1'b1;
      data_filt  <= 1'b1;
      clk_filt_d <= 1'b1;
      clk_cnt    <= '0;
      data_cnt   <= '0;
    end else begin
      clk_filt_d <= clk_filt;

      if (clk_sync[1] != clk_filt) begin
        if (clk_cnt == FCW'(FILTER - 1)) begin
          clk_filt <= clk_sync[1];
          clk_cnt  <= '0;
        end else begin
          clk_cnt <= clk_cnt + FCW'(1);
        end
      end else begin
        clk_cnt <= '0;
      end

      if (data_sync[1] != data_filt) begin
        if (data_cnt == FCW'(FILTER - 1)) begin
          data_filt <= data_sync[1];
          data_cnt  <= '0;
        end else begin
          data_cnt <= data_cnt + FCW'(1);
        end
      end else begin
        data_cnt <= '0;
      end
    end
  end

  assign fe = clk_filt_d & ~clk_filt;

  // Frame FSM with watchdog; hands completed bytes to the decoder one cycle later
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      par_ok     <= 1'b0;
      wd         <= '0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (state == IDLE || fe) begin
        wd <= '0;
      end else begin
        wd <= wd + WDW'(1);
      end

      // wd counts bus-idle cycles since the last falling edge; abort once
      // TIMEOUT of them have elapsed without another edge.
      if (state != IDLE && !fe && wd == WDW'(TIMEOUT - 1)) begin
        frame_err <= 1'b1;
        state     <= IDLE;
        bit_cnt   <= 3'd0;
        shreg     <= 8'h00;
        wd        <= '0;
      end else if (fe) begin
        case (state)
          IDLE: begin
            if (!data_filt) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
              shreg   <= 8'h00;
            end
          end
          DATA: begin
            shreg   <= {data_filt, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par_ok <= ^{data_filt, shreg};
            state  <= STOP;
          end
          STOP: begin
            if (data_filt && par_ok) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Prefix folding: E1 swallows the rest of Pause, E0/F0 qualify the next code
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ps2_key    <= 11'h000;
      key_strobe <= 1'b0;
      ext        <= 1'b0;
      brk        <= 1'b0;
      skip       <= 3'd0;
    end else begin
      key_strobe <= 1'b0;
      if (byte_valid) begin
        if (skip != 3'd0) begin
          skip <= skip - 3'd1;
        end else begin
          case (byte_data)
            8'hE1: begin
              skip <= 3'd7;
              ext  <= 1'b0;
              brk  <= 1'b0;
            end
            8'hE0: ext <= 1'b1;
            8'hF0: brk <= 1'b1;
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
              ext <= 1'b0;
              brk <= 1'b0;
            end
            default: begin
              ps2_key    <= {~ps2_key[10], ~brk, ext, byte_data};
              key_strobe <= 1'b1;
              ext        <= 1'b0;
              brk        <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/ps2_key_encoder.md
# ps2_key_encoder

Converts the raw PS/2 keyboard clock/data lines into the 11-bit `ps2_key` event word that core top levels decode for keyboard controls. It samples, synchronises and glitch-filters the lines, deserialises 11-bit PS/2 frames, and folds the scan-code-set-2 `E0`/`F0`/`E1` prefixes into single key events. The output uses the same encoding the cores already consume:

- bit 10 toggles once per event.
- bit 9 = pressed.
- bit 8 = extended.
- bits 7:0 = code.

## Interface
- `FILTER`, default 8: number of consecutive identical synchronised samples required before a filtered line changes level.
- `TIMEOUT`, default 50000: `clk_sys` cycles without a filtered clock falling edge that abort a partial frame.
- `clk_sys` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous to `clk_sys`.
- `ps2_data` in 1: raw PS/2 data, asynchronous to `clk_sys`.
- `ps2_key` out 11: event word `{toggle, pressed, extended, code[7:0]}`.
- `key_strobe` out 1: one-cycle pulse, asserted in the same cycle `ps2_key` changes.
- `frame_err` out 1: one-cycle pulse on a parity, stop or timeout error.

## Operation
- **Input conditioning**
  - Each line passes through a 2-FF synchroniser, then a filter: a counter per line that, once `FILTER` equal samples differing from the current filtered level are seen, adopts the new level.
  - A filtered clock 1->0 transition is a falling edge (`fe`). Data is sampled from filtered `ps2_data` in the `fe` cycle.
- **Frame FSM**
  - States: `IDLE`, `DATA` (8 bits, LSB first), `PARITY`, `STOP`.
  - `IDLE`: on `fe`, data 0 -> `DATA` with bit count 0. Data 1 -> stay in `IDLE` (spurious edge; no error).
  - `DATA`: shift in one bit per `fe`. After the 8th bit -> `PARITY`.
  - `PARITY`: check that the data bits plus the parity bit have odd weight -> `STOP`. Record pass/fail.
  - `STOP`: on `fe`, if the sampled bit is 1 and parity passed, deliver the byte to the decoder. Otherwise pulse `frame_err`. Go to `IDLE` either way.
  - Watchdog counter is cleared on every `fe` and in `IDLE`. In any non-`IDLE` state, reaching `TIMEOUT` pulses `frame_err`, returns to `IDLE` and discards the partial byte. Decoder prefix flags are unaffected.
- **Byte decoder** (flags `ext`, `brk`, `skip[2:0]`)
  - `skip` != 0: decrement and discard the byte. This has priority over every rule below.
  - `E1`: set `skip` = 7 (Pause sequence swallowed; no event), clear `ext`/`brk`.
  - `E0`: set `ext`.
  - `F0`: set `brk`.
  - `FA`, `AA`, `EE`, `FE`, `00`, `FF`: discard and clear `ext`/`brk`.
  - Any other byte:
    - `ps2_key <= {~ps2_key[10], ~brk, ext, byte}`.
    - Pulse `key_strobe`.
    - Clear `ext`/`brk`.
- **Reset values**
  - `ps2_key` = 11'h000; `key_strobe` = 0; `frame_err` = 0.
  - FSM in `IDLE`; flags, counters and shift register 0.
  - Filtered lines = 1; synchroniser flops = 1.
- **Reset mid-frame or mid-prefix**: all partial state is lost. The next start bit after release begins a fresh frame with no prefix.

## Timing
- Raw edge to `fe`: 2 synchroniser cycles + `FILTER` cycles (±1 for sample phase).
- Stop-bit `fe` in cycle N: byte valid to the decoder in N+1; `ps2_key`/`key_strobe` updated in N+2. Prefix bytes update flags in N+2 with no strobe.
- `frame_err`: asserted in N+1 for stop/parity errors; asserted in the cycle after the watchdog reaches `TIMEOUT` for timeouts.
- Minimum byte spacing on a real bus (~1.1 ms) far exceeds the pipeline depth, so there is no backpressure and no buffering. If a byte completes while the previous event is still in the pipeline, both are delivered in order, one cycle apart.
- `key_strobe` and `frame_err` are never high for more than one consecutive cycle per event.

## Test plan
- **Make code**: from reset, frame `29` (parity bit 0), then bus idle. Expect `ps2_key` = 11'h629 and one `key_strobe` pulse.
- **Break code**: frames `F0`, `29`. Expect exactly one strobe with `ps2_key` = 11'h029; the toggle has flipped from the previous event.
- **Extended key**: frames `E0` `75` -> `ps2_key[9:0]` = 10'h375. Then `E0` `F0` `75` -> `ps2_key[9:0]` = 10'h175, toggle flipped again.
- **Errors and recovery**:
  - Frame `29` with the parity bit inverted: `frame_err` pulses once, `ps2_key` is unchanged, no strobe.
  - Frame `29` with stop = 0: same response.
  - A valid `1C` afterwards: `ps2_key[9:0]` = 10'h21C.
- **Timeout and glitches**:
  - Stop clocking after 5 bits: `frame_err` pulses `TIMEOUT`+1 cycles after the last `fe`. A following valid `16` decodes to 10'h216.
  - A `FILTER`−1-cycle glitch low on `ps2_clk` produces no bit.
- **Pause and reset**:
  - Sequence `E1 14 77 E1 F0 14 F0 77`, then `29`: exactly one strobe, with `ps2_key[9:0]` = 10'h229.
  - Assert `reset` after 4 bits of a frame: all outputs return to 0 immediately. After release, a full `29` frame decodes normally to 11'h629.
